// File: rtl/stage_id.sv
// stage_id: decode/issue stage of the multithreaded pipeline.
// Takes the registered fetch slot, decodes it, and reads the per-thread
// register banks, with bypass from a writeback in the same cycle. A per-thread
// scoreboard turns RAW/WAW-hazarded slots into bubbles and sends their PC back
// to fetch for replay. Issued ops go to EX through an output register.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_itlb_miss, if_icache_miss  fetch miss flags for the presented slot
//   if_pc, if_instruction         PC and instruction word of the slot
//   if_thread                     owning thread of the slot
//   wb_en/wb_thread/wb_reg/wb_data writeback port (also clears scoreboard)
//   ex_*                          registered issued op to EX
//   replay_en/thread/pc           registered single-cycle refetch request
//   hazard                        per-thread stall mask (from state only)
module stage_id #(
    parameter int unsigned n_threads = 4,
    localparam int unsigned TW = (n_threads > 1) ? $clog2(n_threads) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_itlb_miss,
    input  logic                 if_icache_miss,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_instruction,
    input  logic [TW-1:0]        if_thread,
    input  logic                 wb_en,
    input  logic [TW-1:0]        wb_thread,
    input  logic [4:0]           wb_reg,
    input  logic [31:0]          wb_data,
    output logic                 ex_valid,
    output logic [TW-1:0]        ex_thread,
    output logic [31:0]          ex_pc,
    output logic [6:0]           ex_op,
    output logic [4:0]           ex_rd,
    output logic [31:0]          ex_a,
    output logic [31:0]          ex_b,
    output logic [31:0]          ex_imm,
    output logic [1:0]           ex_exc,
    output logic                 replay_en,
    output logic [TW-1:0]        replay_thread,
    output logic [31:0]          replay_pc,
    output logic [n_threads-1:0] hazard
);

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ITLB    = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b10;

    // State
    logic [31:0]          r_regs    [n_threads][32];
    logic [31:0]          r_pending [n_threads];
    logic [31:0]          r_wait    [n_threads];
    logic                 r_ex_valid;
    logic [TW-1:0]        r_ex_thread;
    logic [31:0]          r_ex_pc;
    logic [6:0]           r_ex_op;
    logic [4:0]           r_ex_rd;
    logic [31:0]          r_ex_a;
    logic [31:0]          r_ex_b;
    logic [31:0]          r_ex_imm;
    logic [1:0]           r_ex_exc;
    logic                 r_replay_en;
    logic [TW-1:0]        r_replay_thread;
    logic [31:0]          r_replay_pc;

    // Decode
    logic [6:0]           w_op;
    logic [4:0]           w_rd;
    logic [4:0]           w_rs1;
    logic [4:0]           w_rs2;
    logic [31:0]          w_imm;
    logic                 w_legal;
    logic                 w_wr_rd;
    logic                 w_use_rs1;
    logic                 w_use_rs2;
    logic [31:0]          w_a;
    logic [31:0]          w_b;
    logic [31:0]          w_use_mask;
    logic [31:0]          w_block_mask;
    logic [n_threads-1:0] w_hazard;

    // Issue decision
    logic                 w_issue;
    logic                 w_replay;
    logic                 w_sb_set;
    logic [1:0]           w_exc;
    logic [6:0]           w_ex_op;
    logic [4:0]           w_ex_rd;
    logic [31:0]          w_ex_a;
    logic [31:0]          w_ex_b;
    logic [31:0]          w_ex_imm;

    logic [31:0]          w_pending_nxt [n_threads];
    logic [31:0]          w_wait_nxt    [n_threads];

    assign w_op  = if_instruction[31:25];
    assign w_rd  = if_instruction[24:20];
    assign w_rs1 = if_instruction[19:15];
    assign w_rs2 = if_instruction[14:10];
    assign w_imm = {{17{if_instruction[14]}}, if_instruction[14:0]};

    // Opcode legality and register usage
    always_comb begin
        w_legal   = 1'b0;
        w_wr_rd   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_op)
            7'h00, 7'h01, 7'h02: begin
                w_legal = 1'b1; w_wr_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            7'h10, 7'h11, 7'h14: begin
                w_legal = 1'b1; w_wr_rd = 1'b1; w_use_rs1 = 1'b1;
            end
            7'h12, 7'h13, 7'h30, 7'h32: begin
                w_legal = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            7'h31, 7'h33: begin
                w_legal = 1'b1;
            end
            default: ;
        endcase
    end

    // Register read with same-cycle writeback bypass; r0 is hardwired zero
    always_comb begin
        w_a = 32'h0;
        w_b = 32'h0;
        if (w_rs1 != 5'd0) begin
            if (wb_en && wb_thread == if_thread && wb_reg == w_rs1) w_a = wb_data;
            else                                                     w_a = r_regs[if_thread][w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            if (wb_en && wb_thread == if_thread && wb_reg == w_rs2) w_b = wb_data;
            else                                                     w_b = r_regs[if_thread][w_rs2];
        end
    end

    // Registers that are both used by the slot and pending as of the last edge
    always_comb begin
        w_use_mask = 32'h0;
        if (w_use_rs1) w_use_mask = w_use_mask | (32'(1) << w_rs1);
        if (w_use_rs2) w_use_mask = w_use_mask | (32'(1) << w_rs2);
        if (w_wr_rd)   w_use_mask = w_use_mask | (32'(1) << w_rd);
        w_block_mask = w_use_mask & r_pending[if_thread];
    end

    // Thread t stalls while any register it waited on is still pending
    always_comb begin
        w_hazard = '0;
        for (int unsigned t = 0; t < n_threads; t++) begin
            w_hazard[t] = |(r_wait[t] & r_pending[t]);
        end
    end
    assign hazard = w_hazard;

    // Slot priority: stale fetch, I-cache miss, ITLB miss, illegal, hazard, issue
    always_comb begin
        w_issue  = 1'b0;
        w_replay = 1'b0;
        w_sb_set = 1'b0;
        w_exc    = EXC_NONE;
        w_ex_op  = w_op;
        w_ex_rd  = w_rd;
        w_ex_a   = w_a;
        w_ex_b   = w_b;
        w_ex_imm = w_imm;
        if (w_hazard[if_thread] || if_icache_miss) begin
            // Bubble without replay: stale slot, or the I-cache owns the stall
            w_issue = 1'b0;
        end else if (if_itlb_miss) begin
            w_issue  = 1'b1;
            w_exc    = EXC_ITLB;
            w_ex_op  = 7'h0;
            w_ex_rd  = 5'd0;
            w_ex_a   = 32'h0;
            w_ex_b   = 32'h0;
            w_ex_imm = 32'h0;
        end else if (!w_legal) begin
            w_issue = 1'b1;
            w_exc   = EXC_ILLEGAL;
        end else if (|w_block_mask) begin
            w_replay = 1'b1;
        end else begin
            w_issue  = 1'b1;
            w_sb_set = w_wr_rd && (w_rd != 5'd0);
        end
    end

    // Scoreboard and wait-mask next state; an issue set beats a WB clear
    always_comb begin
        for (int unsigned t = 0; t < n_threads; t++) begin
            w_pending_nxt[t] = r_pending[t];
            if (wb_en && wb_thread == TW'(t)) w_pending_nxt[t][wb_reg] = 1'b0;
            if (w_sb_set && if_thread == TW'(t)) w_pending_nxt[t][w_rd] = 1'b1;
            w_wait_nxt[t] = w_hazard[t] ? r_wait[t] : 32'h0;
            if (w_replay && if_thread == TW'(t)) w_wait_nxt[t] = w_block_mask;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs          <= '{default: '0};
            r_pending       <= '{default: '0};
            r_wait          <= '{default: '0};
            r_ex_valid      <= 1'b0;
            r_ex_thread     <= '0;
            r_ex_pc         <= 32'h0;
            r_ex_op         <= 7'h0;
            r_ex_rd         <= 5'd0;
            r_ex_a          <= 32'h0;
            r_ex_b          <= 32'h0;
            r_ex_imm        <= 32'h0;
            r_ex_exc        <= 2'b00;
            r_replay_en     <= 1'b0;
            r_replay_thread <= '0;
            r_replay_pc     <= 32'h0;
        end else begin
            if (wb_en && wb_reg != 5'd0) r_regs[wb_thread][wb_reg] <= wb_data;
            r_pending   <= w_pending_nxt;
            r_wait      <= w_wait_nxt;
            r_ex_valid  <= w_issue;
            r_replay_en <= w_replay;
            if (w_issue) begin
                r_ex_thread <= if_thread;
                r_ex_pc     <= if_pc;
                r_ex_op     <= w_ex_op;
                r_ex_rd     <= w_ex_rd;
                r_ex_a      <= w_ex_a;
                r_ex_b      <= w_ex_b;
                r_ex_imm    <= w_ex_imm;
                r_ex_exc    <= w_exc;
            end
            if (w_replay) begin
                r_replay_thread <= if_thread;
                r_replay_pc     <= if_pc;
            end
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_thread     = r_ex_thread;
    assign ex_pc         = r_ex_pc;
    assign ex_op         = r_ex_op;
    assign ex_rd         = r_ex_rd;
    assign ex_a          = r_ex_a;
    assign ex_b          = r_ex_b;
    assign ex_imm        = r_ex_imm;
    assign ex_exc        = r_ex_exc;
    assign replay_en     = r_replay_en;
    assign replay_thread = r_replay_thread;
    assign replay_pc     = r_replay_pc;

endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id: directed-vector self-checking bench for stage_id.
module tb_stage_id;

    logic        clk;
    logic        rst;
    logic        if_itlb_miss;
    logic        if_icache_miss;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [1:0]  if_thread;
    logic        wb_en;
    logic [1:0]  wb_thread;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [1:0]  ex_thread;
    logic [31:0] ex_pc;
    logic [6:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [1:0]  ex_exc;
    logic        replay_en;
    logic [1:0]  replay_thread;
    logic [31:0] replay_pc;
    logic [3:0]  hazard;

    int n_checks = 0;
    int n_fail   = 0;

    stage_id #(.n_threads(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_itlb_miss   (if_itlb_miss),
        .if_icache_miss (if_icache_miss),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_thread      (if_thread),
        .wb_en          (wb_en),
        .wb_thread      (wb_thread),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .ex_valid       (ex_valid),
        .ex_thread      (ex_thread),
        .ex_pc          (ex_pc),
        .ex_op          (ex_op),
        .ex_rd          (ex_rd),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_imm         (ex_imm),
        .ex_exc         (ex_exc),
        .replay_en      (replay_en),
        .replay_thread  (replay_thread),
        .replay_pc      (replay_pc),
        .hazard         (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [14:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [1:0] thr, input logic [31:0] pc, input logic [31:0] ins);
        if_icache_miss = 1'b0;
        if_itlb_miss   = 1'b0;
        if_thread      = thr;
        if_pc          = pc;
        if_instruction = ins;
        wb_en          = 1'b0;
    endtask

    task automatic idle();
        slot(2'd0, 32'h0, 32'h0);
        if_icache_miss = 1'b1;
    endtask

    task automatic wb(input logic [1:0] thr, input logic [4:0] r, input logic [31:0] d);
        wb_en     = 1'b1;
        wb_thread = thr;
        wb_reg    = r;
        wb_data   = d;
    endtask

    initial begin
        rst = 1'b1;
        wb_thread = 2'd0;
        wb_reg    = 5'd0;
        wb_data   = 32'h0;
        idle();
        tick();
        tick();
        check("rst_ex_valid", 32'(ex_valid), 32'h0);
        check("rst_hazard",   32'(hazard),   32'h0);
        check("rst_replay",   32'(replay_en), 32'h0);
        rst = 1'b0;

        // RAW on thread 1: ADD r3,r1,r2 then MOV r4,r3
        slot(2'd1, 32'h100, enc(7'h00, 5'd3, 5'd1, {5'd2, 10'd0}));
        tick();
        check("add_valid",  32'(ex_valid),  32'h1);
        check("add_thread", 32'(ex_thread), 32'h1);
        check("add_rd",     32'(ex_rd),     32'h3);
        check("add_pc",     ex_pc,          32'h100);
        check("add_exc",    32'(ex_exc),    32'h0);
        check("add_hazard", 32'(hazard),    32'h0);
        slot(2'd1, 32'h104, enc(7'h14, 5'd4, 5'd3, 15'd0));
        tick();
        check("mov_bubble",   32'(ex_valid),      32'h0);
        check("mov_replay",   32'(replay_en),     32'h1);
        check("mov_rp_thr",   32'(replay_thread), 32'h1);
        check("mov_rp_pc",    replay_pc,          32'h104);
        check("mov_hazard",   32'(hazard),        32'h2);
        check("mov_hold_pc",  ex_pc,              32'h100);
        // Stale slot while hazarded: bubble and no second replay
        slot(2'd1, 32'h104, enc(7'h14, 5'd4, 5'd3, 15'd0));
        tick();
        check("stale_valid",  32'(ex_valid),  32'h0);
        check("stale_replay", 32'(replay_en), 32'h0);
        check("stale_hazard", 32'(hazard),    32'h2);
        idle();
        wb(2'd1, 5'd3, 32'h55);
        tick();
        check("wb_hazard_clr", 32'(hazard),    32'h0);
        check("wb_replay",     32'(replay_en), 32'h0);
        slot(2'd1, 32'h104, enc(7'h14, 5'd4, 5'd3, 15'd0));
        tick();
        check("remov_valid", 32'(ex_valid), 32'h1);
        check("remov_a",     ex_a,          32'h55);
        check("remov_pc",    ex_pc,         32'h104);
        check("remov_rd",    32'(ex_rd),    32'h4);

        // Bypass: STW rs2=r5 on thread 2 with same-cycle WB of r5
        slot(2'd2, 32'h200, enc(7'h13, 5'd0, 5'd0, {5'd5, 10'd0}));
        wb(2'd2, 5'd5, 32'hDEAD);
        tick();
        check("byp_valid", 32'(ex_valid), 32'h1);
        check("byp_b",     ex_b,          32'hDEAD);
        check("byp_a",     ex_a,          32'h0);
        check("byp_imm",   ex_imm,        32'h1400);
        // Negative immediate sign extension
        slot(2'd3, 32'h300, enc(7'h10, 5'd0, 5'd0, 15'h4000));
        tick();
        check("imm_neg", ex_imm, 32'hFFFFC000);
        check("ldb_op",  32'(ex_op), 32'h10);

        // ITLB miss: issues with exc=01, scoreboard untouched (ADD r6 on t0)
        slot(2'd0, 32'h2000, enc(7'h00, 5'd6, 5'd0, 15'd0));
        if_itlb_miss = 1'b1;
        tick();
        check("itlb_valid", 32'(ex_valid), 32'h1);
        check("itlb_exc",   32'(ex_exc),   32'h1);
        check("itlb_pc",    ex_pc,         32'h2000);
        check("itlb_op",    32'(ex_op),    32'h0);
        check("itlb_rd",    32'(ex_rd),    32'h0);
        slot(2'd0, 32'h2004, enc(7'h14, 5'd8, 5'd6, 15'd0));
        tick();
        check("itlb_nopend", 32'(ex_valid),  32'h1);
        check("itlb_norep",  32'(replay_en), 32'h0);
        slot(2'd0, 32'h2008, enc(7'h00, 5'd1, 5'd0, 15'd0));
        if_icache_miss = 1'b1;
        tick();
        check("icm_valid",  32'(ex_valid),  32'h0);
        check("icm_replay", 32'(replay_en), 32'h0);

        // Illegal opcode and thread isolation around pending r9 on t0
        slot(2'd0, 32'h400, enc(7'h00, 5'd9, 5'd0, 15'd0));
        tick();
        check("r9_issue", 32'(ex_valid), 32'h1);
        slot(2'd0, 32'h404, enc(7'h7F, 5'd9, 5'd9, 15'd0));
        tick();
        check("ill_valid", 32'(ex_valid), 32'h1);
        check("ill_exc",   32'(ex_exc),   32'h2);
        check("ill_norep", 32'(replay_en), 32'h0);
        slot(2'd3, 32'h408, enc(7'h14, 5'd10, 5'd9, 15'd0));
        tick();
        check("iso_valid",  32'(ex_valid),  32'h1);
        check("iso_thread", 32'(ex_thread), 32'h3);
        check("iso_norep",  32'(replay_en), 32'h0);

        // Same-cycle set and clear of (t0, r7): set wins
        slot(2'd0, 32'h500, enc(7'h00, 5'd7, 5'd0, 15'd0));
        wb(2'd0, 5'd7, 32'h77);
        tick();
        check("sc_issue", 32'(ex_valid), 32'h1);
        slot(2'd0, 32'h504, enc(7'h14, 5'd11, 5'd7, 15'd0));
        tick();
        check("sc_bubble", 32'(ex_valid),  32'h0);
        check("sc_replay", 32'(replay_en), 32'h1);
        check("sc_rp_pc",  replay_pc,      32'h504);
        check("sc_hazard", 32'(hazard),    32'h1);
        idle();
        wb(2'd0, 5'd7, 32'h77);
        tick();
        check("sc_clr", 32'(hazard), 32'h0);
        // Write to r0 is ignored
        idle();
        wb(2'd0, 5'd0, 32'h1234);
        tick();
        slot(2'd0, 32'h508, enc(7'h14, 5'd12, 5'd0, 15'd0));
        tick();
        check("r0_valid", 32'(ex_valid), 32'h1);
        check("r0_zero",  ex_a,          32'h0);

        // Asynchronous reset mid-cycle
        slot(2'd1, 32'h600, enc(7'h14, 5'd5, 5'd4, 15'd0));
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(ex_valid), 32'h0);
        check("arst_pc",    ex_pc,         32'h0);
        check("arst_a",     ex_a,          32'h0);
        check("arst_rd",    32'(ex_rd),    32'h0);
        tick();
        check("arst_discard", 32'(ex_valid), 32'h0);
        #2;
        rst = 1'b0;
        slot(2'd0, 32'h1000, 32'h00000000);
        tick();
        check("post_valid", 32'(ex_valid), 32'h1);
        check("post_a",     ex_a,          32'h0);
        check("post_b",     ex_b,          32'h0);
        check("post_pc",    ex_pc,         32'h1000);
        // Scoreboard cleared by reset: t1 r4 no longer pending
        slot(2'd1, 32'h1004, enc(7'h14, 5'd5, 5'd4, 15'd0));
        tick();
        check("post_pend_clr", 32'(ex_valid),  32'h1);
        check("post_norep",    32'(replay_en), 32'h0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_id.md
# stage_id

Decode/issue stage of the multithreaded pipeline, directly downstream of the fetch stage. Each cycle it takes fetch's registered outputs (instruction, PC, thread, I-TLB/I-cache miss flags), decodes the instruction, and reads per-thread register banks with writeback bypass. A per-thread scoreboard detects RAW/WAW hazards; a hazarded instruction becomes a bubble, and its PC is returned to fetch for replay. Issued operations go to EX through an output register.

## Interface
- n_threads, 4: number of hardware threads; threadid_t is $clog2(n_threads) bits.
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- if_itlb_miss  in  1  fetch I-TLB miss for the presented slot.
- if_icache_miss  in  1  fetch I-cache miss for the presented slot.
- if_pc  in  32 (vptr_t)  PC of the presented slot.
- if_instruction  in  32 (word_t)  instruction word.
- if_thread  in  threadid_t  owning thread.
- wb_en  in  1  writeback strobe.
- wb_thread  in  threadid_t  writeback thread.
- wb_reg  in  5  writeback register index.
- wb_data  in  32  writeback value.
- ex_valid  out  1  issued op present.
- ex_thread  out  threadid_t  thread of the issued op.
- ex_pc  out  32  PC of the issued op.
- ex_op  out  7  opcode.
- ex_rd  out  5  destination register.
- ex_a, ex_b  out  32  src1 and src2 operand values.
- ex_imm  out  32  sign-extended immediate.
- ex_exc  out  2  exception code: 00 none, 01 ITLB miss, 10 illegal.
- replay_en  out  1  request to refetch.
- replay_thread  out  threadid_t  thread to refetch.
- replay_pc  out  32  PC to refetch.
- hazard  out  n_threads  per-thread stall mask to the scheduler.

## Operation
- Instruction fields: op=[31:25], rd=[24:20], rs1=[19:15], rs2=[14:10], imm=sign-extend of [14:0].
- Legal opcodes: ADD 0x00, SUB 0x01, MUL 0x02, LDB 0x10, LDW 0x11, STB 0x12, STW 0x13, MOV 0x14, BEQ 0x30, JUMP 0x31, TLBWRITE 0x32, IRET 0x33. Any other opcode is illegal.
- Writes rd: ADD, SUB, MUL, LDB, LDW, MOV.
- Reads rs1: all legal ops except JUMP and IRET.
- Reads rs2: ADD, SUB, MUL, STB, STW, BEQ, TLBWRITE.
- Register banks: n_threads × 32 × 32 bits. r0 always reads 0, and writes to r0 are ignored.
- Read bypass: a same-cycle wb_en to the same thread and register returns wb_data.
- Scoreboard: pending[t][r] is set when an op that writes rd issues (r≠0). It is cleared by wb_en for (wb_thread, wb_reg). If set and clear hit the same (t, r) in one cycle, set wins.
- Wait mask: wait[t] is loaded with the set of regs that blocked thread t. hazard[t] = |(wait[t] & pending[t]). When hazard[t] falls, wait[t] clears.
- Per-cycle priority on the input slot:
  1. hazard[if_thread]=1 → bubble, no replay. The slot is a stale fetch.
  2. if_icache_miss=1 → bubble. The I-cache owns the stall.
  3. if_itlb_miss=1 → issue with ex_exc=01, ex_op=0, ex_rd=0, scoreboard untouched.
  4. Illegal opcode → issue with ex_exc=10, scoreboard untouched.
  5. Any used source or destination register is pending → bubble; replay_en=1 with (if_thread, if_pc); wait[if_thread] loaded.
  6. Otherwise issue: ex_valid=1, ex_exc=00, scoreboard updated.
- A bubble drives ex_valid=0. The other ex_* fields hold their previous values.

## Timing
- All outputs are registered. An input slot at edge N appears on ex_* and replay_* at edge N+1.
- hazard is combinational from state (pending, wait). It reflects the scoreboard as updated at the last edge.
- replay_en is a single-cycle pulse per blocked slot.
- A WB clear at edge N removes the hazard in the cycle after N, so the thread can be rescheduled at N+1.
- Reset (asynchronous, any time):
  - all outputs 0, including hazard;
  - pending=0, wait=0, register banks zero.
  - An in-flight issue is discarded.
  - Behaviour is identical mid-operation.

## Test plan
- Reset mid-stream → all outputs 0 immediately. With if_instruction=0x00000000 (ADD r0,r0,r0), thread 0, PC 0x1000, the next edge gives ex_valid=1, ex_a=0, ex_b=0.
- Thread 1 issues ADD r3,r1,r2, then MOV r4,r3 next cycle:
  - MOV → bubble, replay_en=1, replay_thread=1, replay_pc=MOV's PC, hazard=0b0010.
  - wb_en (thread 1, r3, 0x55) → hazard clears next cycle.
  - Refetched MOV issues with ex_a=0x55.
- Bypass: wb_en (thread 2, r5, 0xDEAD) in the same cycle as STW reading rs2=r5 on thread 2 → ex_b=0xDEAD.
- if_itlb_miss=1 with PC 0x2000 → ex_valid=1, ex_exc=01, ex_pc=0x2000, pending unchanged. if_icache_miss=1 → ex_valid=0, no replay.
- Opcode 0x7F → ex_exc=10. The same register index pending on thread 0 does not block thread 3 (thread isolation).
- Same-cycle set/clear of (t0, r7) → pending stays 1. A write to r0 leaves r0 reading 0.
